// File: rtl/reaction_timer_core.sv
// -----------------------------------------------------------------------------
// reaction_timer_core
//
// Reaction-timer game core. The player presses start, waits through a randomised
// arming delay, then reacts as quickly as possible. The reaction time is counted
// in milliseconds with a saturating BCD counter. The core keeps the best (lowest)
// score and punishes a premature press with a FOUL display.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high; returns every register to idle values
//   key_n[1:0]   active-low buttons, asynchronous: [0] start/react, [1] clear best
//   ledr         LED bar: all on while timing, new-best flag in SCORE,
//                alternating pattern in FOUL
//   hex          packed active-low seven-segment digits; digit i at [8i+7:8i],
//                bit 7 = DP (always off), bits 6:0 = g..a
//   state_code   current FSM state: 0 IDLE, 1 ARMED, 2 TIMING, 3 SCORE,
//                4 BEST, 5 FOUL
//   score        last latched reaction time, packed BCD
//   score_valid  one-cycle pulse on the edge that latches score
//   best_valid   the best-score register holds a score
// -----------------------------------------------------------------------------
module reaction_timer_core #(
    parameter int TICK_DIV     = 50000,
    parameter int DIGITS       = 3,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int SHOW_MS      = 3000,
    parameter int LED_W        = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          key_n,
    output logic [LED_W-1:0]    ledr,
    output logic [8*DIGITS-1:0] hex,
    output logic [2:0]          state_code,
    output logic [4*DIGITS-1:0] score,
    output logic                score_valid,
    output logic                best_valid
);

    localparam int DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DLY_W  = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
    localparam int SHOW_W = $clog2(SHOW_MS + 1);
    localparam int BCD_W  = 4 * DIGITS;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_MS - 1);
    localparam logic [BCD_W-1:0]  ALL_NINES = {DIGITS{4'h9}};
    localparam logic [7:0]        SEG_BLANK = 8'hFF;
    localparam logic [7:0]        SEG_DASH  = 8'hBF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        TIMING = 3'd2,
        SCORE  = 3'd3,
        BEST   = 3'd4,
        FOUL   = 3'd5
    } state_t;

    state_t state, state_next;

    logic [1:0]        s1, s2, s3;
    logic [1:0]        press;
    logic [DIV_W-1:0]  div;
    logic              tick;
    logic [15:0]       lfsr;
    logic [DLY_W-1:0]  delay;
    logic [SHOW_W-1:0] show_cnt;
    logic [BCD_W-1:0]  cnt;
    logic [BCD_W-1:0]  score_next;
    logic [BCD_W-1:0]  best;
    logic              new_best;

    // Strobes decoded alongside the next-state logic
    logic load_delay;
    logic enter_timing;
    logic div_clear;
    logic latch_score;
    logic clear_best;

    // Saturating packed-BCD increment: all-nines stays all-nines.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        if (v != ALL_NINES) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (v[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Active-low segment pattern, DP off; non-decimal codes show blank.
    function automatic logic [7:0] seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Falling edge of the synchronised key: a held key yields one press only.
    assign press      = s3 & ~s2;
    assign tick       = (div == DIV_LAST);
    // A press coinciding with a tick includes that tick's increment.
    assign score_next = tick ? bcd_inc(cnt) : cnt;
    assign state_code = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        load_delay   = 1'b0;
        enter_timing = 1'b0;
        latch_score  = 1'b0;
        clear_best   = 1'b0;
        hex          = {DIGITS{SEG_BLANK}};
        ledr         = '0;

        case (state)
            IDLE: begin
                if (press[0]) state_next = ARMED;
            end
            ARMED: begin
                // A press always wins over the expiring tick: that is a false start.
                if (press[0])                          state_next = FOUL;
                else if (tick && delay == DLY_W'(1))   state_next = TIMING;
            end
            TIMING: begin
                ledr = '1;
                for (int i = 0; i < DIGITS; i++) hex[8*i +: 8] = seg(cnt[4*i +: 4]);
                if (press[0]) begin
                    state_next  = SCORE;
                    latch_score = 1'b1;
                end
            end
            SCORE: begin
                ledr[0] = new_best;
                for (int i = 0; i < DIGITS; i++) hex[8*i +: 8] = seg(score[4*i +: 4]);
                if (press[0] || (tick && show_cnt == SHOW_LAST)) state_next = BEST;
            end
            BEST: begin
                for (int i = 0; i < DIGITS; i++)
                    hex[8*i +: 8] = best_valid ? seg(best[4*i +: 4]) : SEG_DASH;
                if (press[1]) begin
                    state_next = IDLE;
                    clear_best = 1'b1;
                end else if (press[0]) begin
                    state_next = ARMED;
                end
            end
            FOUL: begin
                hex = {DIGITS{SEG_DASH}};
                for (int i = 0; i < LED_W; i++) ledr[i] = ~i[0];
                if (tick && show_cnt == SHOW_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (state_next == ARMED  && state != ARMED)  load_delay   = 1'b1;
        if (state_next == TIMING && state != TIMING) enter_timing = 1'b1;
        div_clear = (state_next != state) &&
                    (state_next == ARMED || state_next == TIMING ||
                     state_next == SCORE || state_next == FOUL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= 2'b11;
            s2          <= 2'b11;
            s3          <= 2'b11;
            div         <= '0;
            lfsr        <= 16'hACE1;
            delay       <= '0;
            show_cnt    <= '0;
            cnt         <= '0;
            score       <= '0;
            score_valid <= 1'b0;
            best        <= '0;
            best_valid  <= 1'b0;
            new_best    <= 1'b0;
        end else begin
            s1 <= key_n;
            s2 <= s1;
            s3 <= s2;

            // Fibonacci LFSR, taps 16,14,13,11; free-running so the arming
            // delay depends on when the player presses.
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

            if (div_clear || tick) div <= '0;
            else                   div <= div + DIV_W'(1);

            if (load_delay)
                delay <= DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr[RAND_BITS-1:0]);
            else if (state == ARMED && tick)
                delay <= delay - DLY_W'(1);

            if (div_clear)
                show_cnt <= '0;
            else if (tick && (state == SCORE || state == FOUL))
                show_cnt <= show_cnt + SHOW_W'(1);

            if (enter_timing)
                cnt <= '0;
            else if (state == TIMING && tick)
                cnt <= bcd_inc(cnt);

            score_valid <= latch_score;
            if (latch_score) begin
                score <= score_next;
                // Packed BCD orders the same as the decimal value it encodes.
                if (!best_valid || score_next < best) begin
                    best       <= score_next;
                    best_valid <= 1'b1;
                    new_best   <= 1'b1;
                end else begin
                    new_best   <= 1'b0;
                end
            end else if (clear_best) begin
                best       <= '0;
                best_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/reaction_timer_core.md
# reaction_timer_core

Parametrised reaction-timer controller: a six-state FSM with a millisecond timebase, an LFSR-randomised arming delay, a saturating BCD score counter, best-score tracking and false-start detection. It drives a packed active-low seven-segment bus, the LED bar and a state code. It is the next-generation game core under the DE10-Lite top level, replacing the per-state enable/mux arrangement with a single self-contained block.

## Interface
- TICK_DIV, 50000, clk cycles per 1 ms tick (≥2)
- DIGITS, 3, BCD score digits; score range 0..10^DIGITS−1 ms
- MIN_DELAY_MS, 1000, minimum arming delay in ms
- RAND_BITS, 11, LFSR bits added to delay (≤16)
- SHOW_MS, 3000, dwell time of SCORE and FOUL states in ms
- LED_W, 10, LED bar width (≥2)
- clk  in  1  system clock; the one clock of the block
- reset  in  1  synchronous, active-high
- key_n  in  2  active-low push buttons; [0]=start/react, [1]=clear best; asynchronous
- ledr  out  LED_W  LED bar
- hex  out  8*DIGITS  active-low segments; digit i at [8i+7:8i], bit7=DP (always 1), bits6:0=g..a
- state_code  out  3  current state encoding
- score  out  4*DIGITS  last latched score, BCD
- score_valid  out  1  one-cycle pulse when score latches
- best_valid  out  1  best register holds a score

## Operation
- Key path: per bit, two sync flops s1→s2 plus history flop s3. press = s3 & ~s2 (falling edge). Key held = one press only.
- Timebase: divider 0..TICK_DIV−1. tick is high for the one cycle when divider = TICK_DIV−1. Divider clears to 0 on every entry to ARMED, TIMING, SCORE and FOUL.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Seed 16'hACE1 on reset. Advances every clk.
- States (state_code):
  - IDLE (0): hex blank (all 8'hFF); ledr=0. press[0] → ARMED, loading delay = MIN_DELAY_MS + lfsr[RAND_BITS−1:0].
  - ARMED (1): hex blank; ledr=0. Each tick decrements delay.
    - press[0] → FOUL.
    - tick while delay=1 → TIMING; BCD counter cleared.
  - TIMING (2): ledr all ones; hex shows live counter. Each tick adds 1 BCD, saturating at all-9s.
    - press[0] → SCORE. Latch score; pulse score_valid.
    - If !best_valid or score < best (strict, packed-BCD compare): best ← score, best_valid←1, new_best←1; otherwise new_best←0.
  - SCORE (3): hex shows score; ledr[0]=new_best, other LEDs 0. press[0], or SHOW_MS ticks elapsed → BEST.
  - BEST (4): hex shows best, or dashes (8'hBF per digit) if !best_valid; ledr=0.
    - press[1] → clear best and best_valid → IDLE.
    - else press[0] → ARMED (new delay loaded).
  - FOUL (5): hex all dashes; ledr = alternating pattern, bit0=1 (…0101). All presses ignored. SHOW_MS ticks → IDLE.
  - Codes 6 and 7 → IDLE next cycle.
- Simultaneous events:
  - ARMED: press[0] together with the expiring tick → FOUL.
  - TIMING: press[0] together with tick → latched score includes that increment (saturated).
  - BEST: press[1] and press[0] together → press[1] wins.
- press[1] outside BEST is ignored.
- Digit encoding: 0–9 standard active-low segments; 8'hFF blank; 8'hBF dash.

## Timing
- Reset values (state after reset edge):
  - state=IDLE, state_code=0, ledr=0, hex all 8'hFF.
  - score=0, score_valid=0, best=0, best_valid=0, new_best=0.
  - divider=0, LFSR=16'hACE1, s1/s2/s3=1.
- Key latency: if key_n first sampled low at edge E, press is high during the cycle after E+1, and the state changes at edge E+2. That is 3 edges to the new state_code.
- Outputs are registered or decoded from registered state only; no combinational path from key_n.
- score and score_valid update on the same edge as the TIMING→SCORE transition.
- Reset asserted mid-operation returns to the reset values on the next edge, best included.
- Score resolution: TIMING duration rounded down to whole ticks.

## Test plan
Bench parameters: TICK_DIV=4, DIGITS=3, MIN_DELAY_MS=2, RAND_BITS=2, SHOW_MS=5.
- Reset, then press key_n[0] in IDLE → state_code=1 three edges after key_n falls; delay equals 2 + LFSR[1:0] at the load edge.
- Let ARMED expire, press key_n[0] after 7 ticks in TIMING → score=12'h007, one-cycle score_valid, best=007, best_valid=1, ledr[0]=1 in SCORE.
- Second round with a 9-tick response → score=009, best stays 007, ledr=0 in SCORE. After 5 ticks → BEST showing 007.
- Press key_n[0] during ARMED → FOUL, hex all 8'hBF, ledr=10'b0101010101. Presses ignored. After 5 ticks → IDLE.
- Hold TIMING for 1000+ ticks → counter saturates at 12'h999, and a press latches 999.
- In BEST, assert both keys on the same cycle → best_valid=0, state IDLE. Reset mid-TIMING → all outputs at reset values on the next edge.
